fetch_ctrl: RTL
===============

# fetch_ctrl

Front-end fetch sequencer for the out-of-order core. Owns the fetch PC, issues one-word instruction reads to the icache with at most one request outstanding, and pushes returned {pc, instruction} pairs into the instruction queue. It holds a response when the queue is full and redirects on branch mispredict, discarding any in-flight response. It sits between the icache port and the instruction queue's write side.

## Interface
- RESET_PC, 32'h1eceb000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- redirect  in  1  mispredict/jump, one-cycle pulse, highest priority
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced to 0
- icache_addr  out  32  read address, valid while icache_rmask != 0
- icache_rmask  out  4  4'hF = request this cycle (one-cycle pulse), else 4'h0
- icache_rdata  in  32  instruction word, valid when icache_resp=1
- icache_resp  in  1  response for the single outstanding request, ≥1 cycle after request
- iq_full  in  1  instruction queue cannot accept a push this cycle
- iq_push  out  1  write iq_wdata into queue this cycle
- iq_wdata  out  64  {pc[31:0], inst[31:0]}

## Operation
- Registers: pc (32), hold_inst (32), state ∈ {ISSUE, WAIT, HOLD, SQUASH}.
- Reset: state=ISSUE, pc=RESET_PC, hold_inst=0. While rst=1 all outputs are 0 regardless of other inputs.
- ISSUE: rmask=4'hF, addr=pc; next WAIT. With redirect this cycle: no request, pc<=redirect_pc, stay ISSUE.
- WAIT, no resp: outputs idle, stay WAIT.
- WAIT, resp, !iq_full: iq_push=1, iq_wdata={pc, rdata}; pc<=pc+4; same cycle rmask=4'hF, addr=pc+4; stay WAIT (back-to-back fetch).
- WAIT, resp, iq_full: hold_inst<=rdata, no push, no request; next HOLD.
- HOLD: when !iq_full: push {pc, hold_inst}, pc<=pc+4, next ISSUE (no request this cycle). While iq_full: stay HOLD.
- Redirect priority (overrides all above, no push and no request in that cycle, pc<=redirect_pc):
  - ISSUE or HOLD: next ISSUE; held instruction dropped.
  - WAIT without resp: next SQUASH.
  - WAIT with resp: response dropped, next ISSUE.
  - SQUASH without resp: stay SQUASH (pc updated). SQUASH with resp: next ISSUE.
- SQUASH: no request, no push; on resp discard rdata, next ISSUE.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). redirect_pc low two bits always written as 0.
- Invariants: iq_push=0 whenever iq_full=1; never more than one icache request outstanding; icache_resp in ISSUE or HOLD is a protocol error (ignored, no state change).

## Timing
- icache_rmask, icache_addr, iq_push, iq_wdata are combinational from state, pc, hold_inst and current-cycle redirect/icache_resp/iq_full.
- First request: cycle after rst deasserts, addr=RESET_PC.
- Steady state with 1-cycle icache and queue never full: one push per cycle after the first response.
- Push for a response occurs in the same cycle as icache_resp (or the first !iq_full cycle in HOLD).
- Redirect latency: request to redirect_pc issued the cycle after redirect from ISSUE/HOLD/WAIT-with-resp; from WAIT-without-resp, the cycle after the stale response arrives.
- rst mid-operation overrides everything including an outstanding request; icache must drop its own state on the same rst.

## Test plan
- Reset, 1-cycle icache, iq_full=0 -> requests at 1eceb000, 1eceb004, 1eceb008 on consecutive cycles; pushes {1eceb000,word0},{1eceb004,word1}… one per cycle.
- Response arrives with iq_full=1 for 3 cycles -> no push, no request for 3 cycles; on 4th cycle push held word with its pc, next cycle request pc+4.
- Redirect to 32'h0000_1003 while WAIT, resp 2 cycles later -> stale word never pushed; next request addr=32'h0000_1000.
- Redirect coincident with resp in WAIT -> no push that cycle, next cycle request at redirect_pc; redirect in HOLD -> held word dropped.
- pc=32'hFFFF_FFFC, response accepted -> next request addr=32'h0000_0000.
- rst asserted during WAIT and SQUASH -> all outputs 0 during rst; first post-reset request at RESET_PC; randomized check iq_push never high with iq_full high.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: owns the fetch PC, keeps one icache read
// in flight and pushes {pc, inst} pairs into the instruction queue.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] icache_addr,
    output logic [3:0]  icache_rmask,
    input  logic [31:0] icache_rdata,
    input  logic        icache_resp,
    input  logic        iq_full,
    output logic        iq_push,
    output logic [63:0] iq_wdata
);

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SQUASH = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_inst;

    logic [31:0] w_pc_inc;
    logic [31:0] w_redir_pc;
    logic        w_wait_accept;
    logic        w_hold_drain;

    assign w_pc_inc   = r_pc + 32'd4;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // Response or held word can enter the queue this cycle
    assign w_wait_accept = (r_state == ST_WAIT) && icache_resp && !iq_full;
    assign w_hold_drain  = (r_state == ST_HOLD) && !iq_full;

    // Combinational request/push outputs; reset and redirect silence everything
    always_comb begin
        icache_rmask = 4'h0;
        icache_addr  = 32'h0;
        iq_push      = 1'b0;
        iq_wdata     = 64'h0;
        if (!rst && !redirect) begin
            unique case (r_state)
                ST_ISSUE: begin
                    icache_rmask = 4'hF;
                    icache_addr  = r_pc;
                end
                ST_WAIT: begin
                    if (w_wait_accept) begin
                        iq_push      = 1'b1;
                        iq_wdata     = {r_pc, icache_rdata};
                        icache_rmask = 4'hF;
                        icache_addr  = w_pc_inc;
                    end
                end
                ST_HOLD: begin
                    if (w_hold_drain) begin
                        iq_push  = 1'b1;
                        iq_wdata = {r_pc, r_hold_inst};
                    end
                end
                ST_SQUASH: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Fetch state machine, PC and held-instruction register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ISSUE;
            r_pc        <= RESET_PC;
            r_hold_inst <= 32'h0;
        end else if (redirect) begin
            r_pc <= w_redir_pc;
            unique case (r_state)
                ST_ISSUE:  r_state <= ST_ISSUE;
                ST_HOLD:   r_state <= ST_ISSUE;
                ST_WAIT:   r_state <= icache_resp ? ST_ISSUE : ST_SQUASH;
                ST_SQUASH: r_state <= icache_resp ? ST_ISSUE : ST_SQUASH;
                default:   r_state <= ST_ISSUE;
            endcase
        end else begin
            unique case (r_state)
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (icache_resp) begin
                        if (iq_full) begin
                            r_hold_inst <= icache_rdata;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!iq_full) begin
                        r_pc    <= w_pc_inc;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_SQUASH: begin
                    if (icache_resp) begin
                        r_state <= ST_ISSUE;
                    end
                end
                default: begin
                    r_state <= ST_ISSUE;
                end
            endcase
        end
    end

endmodule
